// File: rtl/lamp_decode_seq.sv
// lamp_decode_seq
//   Decodes a 2-bit lamp index into a registered one-hot lamp drive. A change
//   between two different lamps always passes through an all-off interval of
//   DEAD_CYCLES clocks (break-before-make), so two lamps are never driven at
//   once and lamp never steps directly between two nonzero values.
//
// Parameters
//   DEAD_CYCLES  all-off cycles between two different lamps (1..255)
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       master enable; low forces all lamps off and returns to idle
//   code         requested lamp index (0..3)
//   code_valid   one-cycle strobe qualifying code
//   lamp         registered one-hot lamp drive
//   ready        high when code_valid is sampled this cycle
//   active_code  index of the lit lamp; holds its last value while dark
//   switch_count number of completed lamp turn-ons, wraps at 255
module lamp_decode_seq #(
    parameter int DEAD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] code,
    input  logic       code_valid,
    output logic [3:0] lamp,
    output logic       ready,
    output logic [1:0] active_code,
    output logic [7:0] switch_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_DEAD = 2'd2;

    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES);

    logic [1:0] state;
    logic [1:0] pending;
    logic [7:0] dead_cnt;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        onehot = 4'b0001 << c;
    endfunction

    // Only the dead interval refuses new codes.
    assign ready = (state != S_DEAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            lamp         <= 4'b0000;
            active_code  <= 2'd0;
            switch_count <= 8'd0;
            pending      <= 2'd0;
            dead_cnt     <= 8'd0;
        end else if (!enable) begin
            // Enable low wins over any strobe or dead-time expiry.
            state    <= S_IDLE;
            lamp     <= 4'b0000;
            pending  <= 2'd0;
            dead_cnt <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (code_valid) begin
                        state        <= S_ON;
                        lamp         <= onehot(code);
                        active_code  <= code;
                        switch_count <= switch_count + 8'd1;
                    end
                end
                S_ON: begin
                    // Re-requesting the lit lamp is a no-op.
                    if (code_valid && (code != active_code)) begin
                        state    <= S_DEAD;
                        lamp     <= 4'b0000;
                        pending  <= code;
                        dead_cnt <= DEAD_LOAD;
                    end
                end
                S_DEAD: begin
                    // Counter is loaded with DEAD_CYCLES on entry; the edge
                    // that sees 1 is the last dark cycle's closing edge.
                    if (dead_cnt <= 8'd1) begin
                        state        <= S_ON;
                        lamp         <= onehot(pending);
                        active_code  <= pending;
                        switch_count <= switch_count + 8'd1;
                        dead_cnt     <= 8'd0;
                    end else begin
                        dead_cnt <= dead_cnt - 8'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    lamp     <= 4'b0000;
                    dead_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule
